// File: rtl/downcounter_pkg.sv
// Shared encodings for the loadable down-counter timer: FSM states and counting modes.
package downcounter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/downcounter_timer.sv
// Loadable down-counter with registered one-cycle terminal-count pulse, one-shot or auto-reload.
// Load takes effect on the next edge and always beats enable; busy/done decode the state register.
module downcounter_timer
   import downcounter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             mode,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   state_t           state, state_n;
   logic [WIDTH-1:0] count_n;
   logic [WIDTH-1:0] reload_r, reload_n;
   logic             mode_r, mode_n;
   logic             tc_n;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         reload_r <= '0;
         mode_r   <= MODE_ONESHOT;
         tc       <= 1'b0;
      end else begin
         state    <= state_n;
         count    <= count_n;
         reload_r <= reload_n;
         mode_r   <= mode_n;
         tc       <= tc_n;
      end
   end

   always_comb begin
      state_n  = state;
      count_n  = count;
      reload_n = reload_r;
      mode_n   = mode_r;
      tc_n     = 1'b0;

      if (load) begin
         // A zero load value means "stop": park in IDLE rather than start a zero-length count.
         if (load_value != '0) begin
            count_n  = load_value;
            reload_n = load_value;
            mode_n   = mode;
            state_n  = RUN;
         end else begin
            count_n = '0;
            state_n = IDLE;
         end
      end else begin
         case (state)
            RUN: begin
               if (enable) begin
                  if (count > WIDTH'(1)) begin
                     count_n = count - WIDTH'(1);
                  end else begin
                     tc_n = 1'b1;
                     if (mode_r == MODE_PERIODIC) begin
                        count_n = reload_r;
                     end else begin
                        count_n = '0;
                        state_n = DONE;
                     end
                  end
               end
            end
            DONE: begin
               count_n = '0;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_downcounter_timer.sv
// Directed self-checking bench for downcounter_timer (WIDTH = 4).
module tb_downcounter_timer;

   localparam int WIDTH = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             load = 1'b0;
   logic [WIDTH-1:0] load_value = '0;
   logic             mode = 1'b0;
   logic             enable = 1'b0;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             busy;
   logic             done;

   int tests = 0;
   int fails = 0;

   downcounter_timer #(.WIDTH(WIDTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .load       (load),
      .load_value (load_value),
      .mode       (mode),
      .enable     (enable),
      .count      (count),
      .tc         (tc),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_load(input logic [WIDTH-1:0] v, input logic m, input logic en);
      load = 1'b1; load_value = v; mode = m; enable = en;
      step();
      load = 1'b0;
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #1;
      tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
      tests++; if (tc !== 1'b0)    begin fails++; $display("FAIL reset_tc got %b want 0", tc); end
      tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (done !== 1'b0)  begin fails++; $display("FAIL reset_done got %b want 0", done); end
      @(negedge clock) reset = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      do_load(4'd9, 1'b0, 1'b0);
      tests++; if (count !== 4'd9 || busy !== 1'b1) begin fails++; $display("FAIL midrun_load count=%0d busy=%b want 9/1", count, busy); end
      enable = 1'b1;
      repeat (3) step();
      tests++; if (count !== 4'd6) begin fails++; $display("FAIL midrun_count got %0d want 6", count); end
      #2 reset = 1'b1;
      #1;
      tests++; if (count !== 4'd0 || busy !== 1'b0 || tc !== 1'b0)
         begin fails++; $display("FAIL midrun_async_reset count=%0d busy=%b tc=%b want 0/0/0", count, busy, tc); end
      enable = 1'b0;
      @(negedge clock) reset = 1'b0;
   endtask

   task automatic test_oneshot();
      logic [WIDTH-1:0] exp;
      do_load(4'd5, 1'b0, 1'b1);
      tests++; if (count !== 4'd5 || tc !== 1'b0) begin fails++; $display("FAIL oneshot_load count=%0d tc=%b want 5/0", count, tc); end
      exp = 4'd5;
      for (int i = 0; i < 5; i++) begin
         step();
         exp = exp - 4'd1;
         tests++; if (count !== exp || tc !== (exp == 4'd0))
            begin fails++; $display("FAIL oneshot_seq count=%0d tc=%b want %0d/%b", count, tc, exp, exp == 4'd0); end
      end
      tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL oneshot_done done=%b busy=%b want 1/0", done, busy); end
      for (int i = 0; i < 10; i++) begin
         step();
         tests++; if (count !== 4'd0 || tc !== 1'b0 || done !== 1'b1)
            begin fails++; $display("FAIL oneshot_hold count=%0d tc=%b done=%b want 0/0/1", count, tc, done); end
      end
      enable = 1'b0;
   endtask

   task automatic test_periodic();
      logic [WIDTH-1:0] exp;
      int pulses;
      do_load(4'd3, 1'b1, 1'b1);
      tests++; if (count !== 4'd3) begin fails++; $display("FAIL periodic_load got %0d want 3", count); end
      exp = 4'd3;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         exp = (exp == 4'd1) ? 4'd3 : exp - 4'd1;
         if (tc === 1'b1) pulses++;
         tests++; if (count !== exp || tc !== (i % 3 == 2) || busy !== 1'b1)
            begin fails++; $display("FAIL periodic_seq count=%0d tc=%b busy=%b want %0d/%b/1", count, tc, busy, exp, i % 3 == 2); end
      end
      tests++; if (pulses != 4) begin fails++; $display("FAIL periodic_pulses got %0d want 4", pulses); end
      enable = 1'b0;
   endtask

   task automatic test_enable_gaps();
      logic [WIDTH-1:0] exp;
      do_load(4'd4, 1'b0, 1'b0);
      exp = 4'd4;
      for (int i = 1; i <= 8; i++) begin
         enable = (i % 2 == 0);
         step();
         if (enable) exp = exp - 4'd1;
         tests++; if (count !== exp || tc !== (i == 8))
            begin fails++; $display("FAIL gaps_edge%0d count=%0d tc=%b want %0d/%b", i, count, tc, exp, i == 8); end
      end
      enable = 1'b0;
   endtask

   task automatic test_priority();
      do_load(4'd2, 1'b1, 1'b0);
      enable = 1'b1;
      step();
      tests++; if (count !== 4'd1) begin fails++; $display("FAIL prio_setup got %0d want 1", count); end
      do_load(4'd7, 1'b1, 1'b1);
      tests++; if (count !== 4'd7 || tc !== 1'b0 || busy !== 1'b1)
         begin fails++; $display("FAIL prio_load_wins count=%0d tc=%b busy=%b want 7/0/1", count, tc, busy); end
      do_load(4'd0, 1'b1, 1'b1);
      tests++; if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0)
         begin fails++; $display("FAIL prio_load_zero count=%0d busy=%b done=%b tc=%b want 0/0/0/0", count, busy, done, tc); end
      step();
      tests++; if (count !== 4'd0 || busy !== 1'b0) begin fails++; $display("FAIL prio_idle_hold count=%0d busy=%b want 0/0", count, busy); end
      enable = 1'b0;
   endtask

   task automatic test_width_edge();
      int edges;
      logic bad;
      logic [WIDTH-1:0] prev;
      do_load(4'd15, 1'b0, 1'b1);
      tests++; if (count !== 4'd15) begin fails++; $display("FAIL width_load got %0d want 15", count); end
      edges = 0;
      bad = 1'b0;
      prev = count;
      while (tc !== 1'b1 && edges < 40) begin
         step();
         edges++;
         if (count === 4'd15 || count > prev) bad = 1'b1;
         prev = count;
      end
      tests++; if (edges != 15) begin fails++; $display("FAIL width_edges got %0d want 15", edges); end
      tests++; if (bad !== 1'b0) begin fails++; $display("FAIL width_monotonic got %b want 0", bad); end
      step();
      tests++; if (count !== 4'd0 || done !== 1'b1) begin fails++; $display("FAIL width_nowrap count=%0d done=%b want 0/1", count, done); end
      enable = 1'b0;
   endtask

   initial begin
      test_reset();
      test_reset_mid_run();
      test_oneshot();
      test_periodic();
      test_enable_gaps();
      test_priority();
      test_width_edge();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout tests=%0d", tests);
      $fatal(1);
   end

endmodule
